// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Includes state codes, opcodes, funct fields, ALUOp and ALU control values.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU function decoder: maps ALUOp and the R-type funct field to the ALU control code.
// Purely combinational.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALUCTL_ADD;
        unique case (aluop)
            ALUOP_ADD: alucontrol = ALUCTL_ADD;
            ALUOP_SUB: alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol = ALUCTL_SUB;
                    FUNCT_AND: alucontrol = ALUCTL_AND;
                    FUNCT_OR:  alucontrol = ALUCTL_OR;
                    FUNCT_SLT: alucontrol = ALUCTL_SLT;
                    default:   alucontrol = ALUCTL_ADD;
                endcase
            end
            default: alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Moore control FSM for the single-memory multicycle MIPS core.
// Also provides the retired-instruction counter and the illegal-opcode pulse.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcen,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    state_t     state_q;
    state_t     state_d;
    logic       op_known;
    logic       retire;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       memwrite_s;
    logic [1:0] aluop;

    assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = (op == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StFetch;
        endcase
    end

    // Every state that closes an instruction returns to fetch.
    assign retire = (state_q == StMemWb) || (state_q == StMemWr) || (state_q == StAluWb) ||
                    (state_q == StAddiWb) || (state_q == StBranch) || (state_q == StJump);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            illegal <= (state_q == StDecode) && !op_known;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (state_q)
            StFetch: begin
                alusrcb   = 2'b01;
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
            end
            StDecode: alusrcb = 2'b11;
            StMemAdr, StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            StMemWr: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            StExec: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            StAluWb: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            StBranch: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            StAddiWb: regwrite_s = 1'b1;
            StJump: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are blocked combinationally so nothing commits while reset is held.
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign irwrite  = irwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign state    = state_q;

    mc_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit.
// Walks each instruction class through its state sequence and checks decoded controls.
module tb_mc_control_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        pcen;
    logic        memwrite;
    logic        irwrite;
    logic        regwrite;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic        iord;
    logic        memtoreg;
    logic        regdst;
    logic [1:0]  pcsrc;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state;

    int          vec_cnt;
    int          err_cnt;
    logic [31:0] exp_instret;

    mc_control_unit #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .instret    (instret),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;
        #12;
        vec_cnt++;
        if (state !== 4'd0) begin
            err_cnt++; $display("FAIL rst_state got %0d want 0", state);
        end
        vec_cnt++;
        if ({pcen, irwrite, regwrite, memwrite} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL rst_enables got %b want 0000", {pcen, irwrite, regwrite, memwrite});
        end
        vec_cnt++;
        if (alusrcb !== 2'b01) begin
            err_cnt++; $display("FAIL rst_alusrcb got %b want 01", alusrcb);
        end
        #10;
        reset = 1'b0;
        #1;
        vec_cnt++;
        if ({pcen, irwrite} !== 2'b11) begin
            err_cnt++; $display("FAIL fetch_en got %b want 11", {pcen, irwrite});
        end
        vec_cnt++;
        if (instret !== 32'd0 || illegal !== 1'b0) begin
            err_cnt++; $display("FAIL rst_cnt got %0d/%b want 0/0", instret, illegal);
        end
        exp_instret = 32'd0;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            vec_cnt++;
            if (state !== exp_st[i]) begin
                err_cnt++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp_st[i]);
            end
            vec_cnt++;
            if ({memwrite, regwrite, memtoreg} !== {1'b0, i == 4, i == 4}) begin
                err_cnt++;
                $display("FAIL lw_ctl[%0d] got %b want 0%b%b", i,
                         {memwrite, regwrite, memtoreg}, i == 4, i == 4);
            end
        end
        exp_instret = exp_instret + 1;
        vec_cnt++;
        if (instret !== exp_instret) begin
            err_cnt++; $display("FAIL lw_instret got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        op = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            vec_cnt++;
            if (state !== exp_st[i]) begin
                err_cnt++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp_st[i]);
            end
            vec_cnt++;
            if ({memwrite, iord, regwrite} !== {i == 3, i == 3, 1'b0}) begin
                err_cnt++;
                $display("FAIL sw_ctl[%0d] got %b want %b%b0", i,
                         {memwrite, iord, regwrite}, i == 3, i == 3);
            end
        end
        exp_instret = exp_instret + 1;
        vec_cnt++;
        if (instret !== exp_instret) begin
            err_cnt++; $display("FAIL sw_instret got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_rtype(input logic [5:0] f, input logic [2:0] exp_ctl);
        op    = 6'b000000;
        funct = f;
        tick();
        tick();
        vec_cnt++;
        if (state !== 4'd6 || alucontrol !== exp_ctl || alusrca !== 1'b1 || alusrcb !== 2'b00) begin
            err_cnt++;
            $display("FAIL r_exec st=%0d ctl=%b srca=%b srcb=%b want 6/%b/1/00",
                     state, alucontrol, alusrca, alusrcb, exp_ctl);
        end
        tick();
        vec_cnt++;
        if (state !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1) begin
            err_cnt++;
            $display("FAIL r_aluwb st=%0d regdst=%b regwrite=%b want 7/1/1", state, regdst, regwrite);
        end
        tick();
        exp_instret = exp_instret + 1;
        vec_cnt++;
        if (state !== 4'd0 || instret !== exp_instret) begin
            err_cnt++;
            $display("FAIL r_done st=%0d instret=%0d want 0/%0d", state, instret, exp_instret);
        end
    endtask

    task automatic test_beq(input logic z);
        op   = 6'b000100;
        zero = z;
        tick();
        vec_cnt++;
        if (state !== 4'd1 || pcen !== 1'b0 || alusrcb !== 2'b11) begin
            err_cnt++;
            $display("FAIL beq_dec st=%0d pcen=%b srcb=%b want 1/0/11", state, pcen, alusrcb);
        end
        tick();
        vec_cnt++;
        if (state !== 4'd8 || pcen !== z || pcsrc !== 2'b01 || alucontrol !== 3'b110) begin
            err_cnt++;
            $display("FAIL beq_br st=%0d pcen=%b pcsrc=%b ctl=%b want 8/%b/01/110",
                     state, pcen, pcsrc, alucontrol, z);
        end
        tick();
        exp_instret = exp_instret + 1;
        vec_cnt++;
        if (state !== 4'd0 || instret !== exp_instret) begin
            err_cnt++;
            $display("FAIL beq_done st=%0d instret=%0d want 0/%0d", state, instret, exp_instret);
        end
        zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        op = 6'b001000;
        tick();
        tick();
        vec_cnt++;
        if (state !== 4'd9 || alusrcb !== 2'b10 || alusrca !== 1'b1) begin
            err_cnt++;
            $display("FAIL addi_ex st=%0d srca=%b srcb=%b want 9/1/10", state, alusrca, alusrcb);
        end
        tick();
        vec_cnt++;
        if (state !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0) begin
            err_cnt++;
            $display("FAIL addi_wb st=%0d rw=%b rd=%b want 10/1/0", state, regwrite, regdst);
        end
        tick();
        exp_instret = exp_instret + 1;
        op = 6'b000010;
        tick();
        tick();
        vec_cnt++;
        if (state !== 4'd11 || pcen !== 1'b1 || pcsrc !== 2'b10) begin
            err_cnt++;
            $display("FAIL j_st st=%0d pcen=%b pcsrc=%b want 11/1/10", state, pcen, pcsrc);
        end
        tick();
        exp_instret = exp_instret + 1;
        vec_cnt++;
        if (state !== 4'd0 || instret !== exp_instret) begin
            err_cnt++;
            $display("FAIL j_done st=%0d instret=%0d want 0/%0d", state, instret, exp_instret);
        end
    endtask

    task automatic test_illegal_and_reset();
        op = 6'b111111;
        tick();
        vec_cnt++;
        if (state !== 4'd1 || illegal !== 1'b0) begin
            err_cnt++; $display("FAIL ill_dec st=%0d ill=%b want 1/0", state, illegal);
        end
        tick();
        vec_cnt++;
        if (state !== 4'd0 || illegal !== 1'b1 || instret !== exp_instret) begin
            err_cnt++;
            $display("FAIL ill_pulse st=%0d ill=%b instret=%0d want 0/1/%0d",
                     state, illegal, instret, exp_instret);
        end
        op = 6'b100011;
        tick();
        vec_cnt++;
        if (state !== 4'd1 || illegal !== 1'b0) begin
            err_cnt++; $display("FAIL ill_clear st=%0d ill=%b want 1/0", state, illegal);
        end
        tick();
        tick();
        vec_cnt++;
        if (state !== 4'd3 || iord !== 1'b1) begin
            err_cnt++; $display("FAIL lw_memrd st=%0d iord=%b want 3/1", state, iord);
        end
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (state !== 4'd0 || regwrite !== 1'b0 || pcen !== 1'b0 || instret !== 32'd0) begin
            err_cnt++;
            $display("FAIL mid_rst st=%0d rw=%b pcen=%b instret=%0d want 0/0/0/0",
                     state, regwrite, pcen, instret);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_instret = 32'd0;
        tick();
        vec_cnt++;
        if (state !== 4'd1 || regwrite !== 1'b0 || instret !== exp_instret) begin
            err_cnt++;
            $display("FAIL post_rst st=%0d rw=%b instret=%0d want 1/0/0", state, regwrite, instret);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype(6'b101010, 3'b111);
        test_rtype(6'b100010, 3'b110);
        test_rtype(6'b100100, 3'b000);
        test_rtype(6'b100101, 3'b001);
        test_rtype(6'b111000, 3'b010);
        test_beq(1'b1);
        test_beq(1'b0);
        test_back_to_back();
        test_illegal_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
